// File: rtl/cache_sec_pkg.sv
// Shared cache-security types: flush walker state encoding and default cache geometry.
package cache_sec_pkg;

    localparam int CACHE_SETS_DEF = 64;
    localparam int CACHE_WAYS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WB    = 3'd3,
        INV   = 3'd4,
        DONE  = 3'd5
    } flush_state_t;

endpackage

// File: rtl/cache_flush_ctr.sv
// Set/way walk counter: synchronous clear, way-major advance with set carry, last-line flag.
// Latency: clear/advance visible the cycle after; last is combinational from the counters.
// Backpressure: none; advances only when adv is asserted.
module cache_flush_ctr #(
    parameter int SETS  = 64,
    parameter int WAYS  = 4,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] line_set,
    output logic [WAY_W-1:0] line_way,
    output logic             last
);

    logic way_last;

    assign way_last = (line_way == WAY_W'(WAYS - 1));
    assign last     = way_last && (line_set == IDX_W'(SETS - 1));

    // Power-of-two geometry lets both counters wrap naturally to 0 after the last line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_set <= '0;
            line_way <= '0;
        end else if (clr) begin
            line_set <= '0;
            line_way <= '0;
        end else if (adv) begin
            line_way <= line_way + WAY_W'(1);
            if (way_last) begin
                line_set <= line_set + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_flush_seq.sv
// Full-cache flush walker: read tag, write back dirty lines (CACHE_FLUSH_WB_EN), invalidate every set/way.
// Latency: first tag read the cycle after flush_req_i; 3 cycles per clean line, 3+n with an n-cycle writeback.
// Backpressure: WB holds until wb_ack_i; requests during a walk coalesce into one pending rerun.
module cache_flush_seq
    import cache_sec_pkg::*;
#(
    parameter int SETS  = CACHE_SETS_DEF,
    parameter int WAYS  = CACHE_WAYS_DEF,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             tag_rd_en_o,
    output logic [IDX_W-1:0] line_set_o,
    output logic [WAY_W-1:0] line_way_o,
    input  logic             tag_valid_i,
    input  logic             tag_dirty_i,
    output logic             wb_req_o,
    input  logic             wb_ack_i,
    output logic             inv_we_o
);

    flush_state_t state_q, state_d;
    logic         pend_q, pend_d;
    logic         busy_q;
    logic         ctr_clr, ctr_adv, ctr_last;

    cache_flush_ctr #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ctr_clr),
        .adv      (ctr_adv),
        .line_set (line_set_o),
        .line_way (line_way_o),
        .last     (ctr_last)
    );

`ifndef CACHE_FLUSH_WB_EN
    logic unused_wb_inputs;
    assign unused_wb_inputs = tag_valid_i ^ tag_dirty_i ^ wb_ack_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign busy_o = busy_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ctr_clr     = 1'b0;
        ctr_adv     = 1'b0;
        tag_rd_en_o = 1'b0;
        wb_req_o    = 1'b0;
        inv_we_o    = 1'b0;
        done_o      = 1'b0;

        // Any request seen while not idle, including in DONE, is remembered once.
        if (state_q != IDLE && flush_req_i) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    ctr_clr = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                tag_rd_en_o = 1'b1;
                state_d     = CHECK;
            end
            CHECK: begin
`ifdef CACHE_FLUSH_WB_EN
                state_d = (tag_valid_i && tag_dirty_i) ? WB : INV;
`else
                state_d = INV;
`endif
            end
            WB: begin
`ifdef CACHE_FLUSH_WB_EN
                wb_req_o = 1'b1;
                if (wb_ack_i) begin
                    state_d = INV;
                end
`else
                state_d = INV;
`endif
            end
            INV: begin
                inv_we_o = 1'b1;
                ctr_adv  = 1'b1;
                state_d  = ctr_last ? DONE : READ;
            end
            DONE: begin
                done_o  = 1'b1;
                ctr_clr = 1'b1;
                pend_d  = 1'b0;
                state_d = (pend_q || flush_req_i) ? READ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_flush_seq.sv
// Randomized scoreboard bench for cache_flush_seq (SETS=4, WAYS=2) with a tag-array/writeback responder.
module tb_cache_flush_seq;

    localparam int TS   = 4;
    localparam int TW   = 2;
    localparam int MAXC = 20000;
`ifdef CACHE_FLUSH_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef struct {
        int s;
        int w;
        int c;
        int n;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       flush_req_i;
    logic       busy_o;
    logic       done_o;
    logic       tag_rd_en_o;
    logic [1:0] line_set_o;
    logic [0:0] line_way_o;
    logic       tag_valid_i;
    logic       tag_dirty_i;
    logic       wb_req_o;
    logic       wb_ack_i;
    logic       inv_we_o;

    cache_flush_seq #(.SETS(TS), .WAYS(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req_i (flush_req_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tag_rd_en_o (tag_rd_en_o),
        .line_set_o  (line_set_o),
        .line_way_o  (line_way_o),
        .tag_valid_i (tag_valid_i),
        .tag_dirty_i (tag_dirty_i),
        .wb_req_o    (wb_req_o),
        .wb_ack_i    (wb_ack_i),
        .inv_we_o    (inv_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_chk = 0;
    int  n_err = 0;
    bit  in_reset;
    bit  busy_exp [0:MAXC-1];
    ev_t q_rd[$];
    ev_t q_wb[$];
    ev_t q_inv[$];
    int  q_done[$];

    // Tag array as seen by the responder, and the reference copy used for planning.
    bit  mem_v [TS][TW];
    bit  mem_d [TS][TW];
    bit  m_v   [TS][TW];
    bit  m_d   [TS][TW];
    int  dly   [TS][TW];

    int  last_done, done_cnt, inv_cnt, wb_eps;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse();
        flush_req_i = 1'b1;
        @(negedge clk);
        flush_req_i = 1'b0;
    endtask

    // mode 0 clean, 1 directed mix, 2 all valid+dirty, 3 random
    task automatic init_mem(input int mode);
        for (int s = 0; s < TS; s++) begin
            for (int w = 0; w < TW; w++) begin
                bit v, d;
                int k;
                v = 1'b0; d = 1'b0; k = 0;
                if (mode == 2) begin v = 1'b1; d = 1'b1; k = $urandom_range(0, 3); end
                if (mode == 3) begin v = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); k = $urandom_range(0, 4); end
                mem_v[s][w] = v; mem_d[s][w] = d; m_v[s][w] = v; m_d[s][w] = d; dly[s][w] = k;
            end
        end
        if (mode == 1) begin
            mem_v[2][1] = 1'b1; mem_d[2][1] = 1'b1; m_v[2][1] = 1'b1; m_d[2][1] = 1'b1; dly[2][1] = 4;
            mem_v[1][0] = 1'b0; mem_d[1][0] = 1'b1; m_v[1][0] = 1'b0; m_d[1][0] = 1'b1;
            mem_v[0][1] = 1'b1; mem_d[0][1] = 1'b0; m_v[0][1] = 1'b1; m_d[0][1] = 1'b0;
        end
    endtask

    // Expected event schedule of one walk starting with a request sampled at the end of cycle k.
    task automatic plan(input int k, output int d);
        int  c;
        ev_t e;
        c = k + 1;
        for (int s = 0; s < TS; s++) begin
            for (int w = 0; w < TW; w++) begin
                e.s = s; e.w = w; e.c = c; e.n = 0;
                q_rd.push_back(e);
                if (WB_EN && m_v[s][w] && m_d[s][w]) begin
                    e.c = c + 2; e.n = dly[s][w] + 1;
                    q_wb.push_back(e);
                    c = c + 2 + e.n;
                end else begin
                    c = c + 2;
                end
                e.c = c; e.n = 0;
                q_inv.push_back(e);
                c++;
                m_v[s][w] = 1'b0; m_d[s][w] = 1'b0;
            end
        end
        for (int i = k + 1; i <= c; i++) busy_exp[i] = 1'b1;
        q_done.push_back(c);
        d = c;
    endtask

    task automatic start_walk(output int k, output int d);
        k = cyc;
        plan(k, d);
        pulse();
    endtask

    // Responder: tag data one cycle after the read strobe, acks after dly cycles, clears on invalidate.
    initial begin
        bit rd_p;
        int rd_s, rd_w, wb_cnt;
        rd_p = 1'b0; rd_s = 0; rd_w = 0; wb_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_p = 1'b0; wb_cnt = 0; wb_ack_i = 1'b0;
            end else begin
                if (inv_we_o) begin
                    mem_v[line_set_o][line_way_o] = 1'b0;
                    mem_d[line_set_o][line_way_o] = 1'b0;
                end
                rd_p = tag_rd_en_o; rd_s = int'(line_set_o); rd_w = int'(line_way_o);
                if (wb_req_o) begin
                    wb_ack_i = (wb_cnt == dly[line_set_o][line_way_o]);
                    wb_cnt++;
                end else begin
                    wb_cnt   = 0;
                    wb_ack_i = 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
            #1;
            if (rd_p) begin
                tag_valid_i = mem_v[rd_s][rd_w];
                tag_dirty_i = mem_d[rd_s][rd_w];
            end else begin
                tag_valid_i = 1'($urandom_range(0, 1));
                tag_dirty_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    ev_t mon_e, wb_e;
    bit  wb_prev;
    int  wb_start;
    always @(negedge clk) begin
        if (in_reset) begin
            wb_prev = 1'b0;
        end else begin
            chk("busy", busy_o, busy_exp[cyc]);
            if (!busy_exp[cyc])
                chk("idle_outputs", {done_o, tag_rd_en_o, wb_req_o, inv_we_o, line_set_o, line_way_o}, 0);
            if (tag_rd_en_o) begin
                if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    mon_e = q_rd.pop_front();
                    chk("rd_set", line_set_o, mon_e.s);
                    chk("rd_way", line_way_o, mon_e.w);
                    chk("rd_cycle", cyc, mon_e.c);
                end
            end
            if (wb_req_o && !wb_prev) begin
                wb_eps++;
                wb_start = cyc;
                if (q_wb.size() == 0) chk("wb_unexpected", 1, 0);
                else begin
                    wb_e = q_wb.pop_front();
                    chk("wb_set", line_set_o, wb_e.s);
                    chk("wb_way", line_way_o, wb_e.w);
                    chk("wb_start", cyc, wb_e.c);
                end
            end else if (wb_req_o && wb_prev) begin
                chk("wb_set_stable", line_set_o, wb_e.s);
                chk("wb_way_stable", line_way_o, wb_e.w);
            end
            if (!wb_req_o && wb_prev) chk("wb_len", cyc - wb_start, wb_e.n);
            wb_prev = wb_req_o;
            if (inv_we_o) begin
                inv_cnt++;
                if (q_inv.size() == 0) chk("inv_unexpected", 1, 0);
                else begin
                    mon_e = q_inv.pop_front();
                    chk("inv_set", line_set_o, mon_e.s);
                    chk("inv_way", line_way_o, mon_e.w);
                    chk("inv_cycle", cyc, mon_e.c);
                end
            end
            if (done_o) begin
                done_cnt++;
                last_done = cyc;
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, q_done.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d, d2, r1, base_done, base_inv, base_wb, sum;
        in_reset = 1'b1;
        rst_n = 1'b0; flush_req_i = 1'b0; tag_valid_i = 1'b0; tag_dirty_i = 1'b0; wb_ack_i = 1'b0;
        last_done = 0; done_cnt = 0; inv_cnt = 0; wb_eps = 0; wb_prev = 1'b0; wb_start = 0;
        init_mem(0);
        #1;
        chk("reset_outputs", {busy_o, done_o, tag_rd_en_o, wb_req_o, inv_we_o, line_set_o, line_way_o}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        wait_cyc(cyc + 3);

        // All clean: 8 invalidates in order, done 25 cycles after the request cycle.
        base_inv = inv_cnt;
        start_walk(k, d);
        wait_cyc(d + 3);
        chk("clean_done_latency", last_done - k, 25);
        chk("clean_inv_count", inv_cnt - base_inv, 8);

        // Dirty (2,1) with a 4-cycle ack delay; invalid-but-dirty (1,0) must not write back.
        init_mem(1);
        base_wb = wb_eps;
        start_walk(k, d);
        wait_cyc(d + 3);
        chk("dirty_done_latency", last_done - k, WB_EN ? 30 : 25);
        chk("dirty_wb_count", wb_eps - base_wb, WB_EN ? 1 : 0);

        // All valid+dirty: writebacks only in the WB build, clean-line timing otherwise.
        init_mem(2);
        sum = 0;
        for (int s = 0; s < TS; s++) for (int w = 0; w < TW; w++) sum += dly[s][w] + 1;
        base_wb = wb_eps;
        start_walk(k, d);
        wait_cyc(d + 3);
        chk("alldirty_done_latency", last_done - k, 25 + (WB_EN ? sum : 0));
        chk("alldirty_wb_count", wb_eps - base_wb, WB_EN ? 8 : 0);

        // Two extra requests (one mid-walk, one in the DONE cycle) coalesce into a single rerun.
        init_mem(3);
        base_done = done_cnt; base_inv = inv_cnt;
        start_walk(k, d);
        r1 = k + 1 + $urandom_range(0, d - k - 3);
        wait_cyc(r1);
        plan(d, d2);
        pulse();
        wait_cyc(d);
        pulse();
        wait_cyc(d2 + 4);
        chk("pending_done_pulses", done_cnt - base_done, 2);
        chk("pending_inv_count", inv_cnt - base_inv, 16);

        // Reset mid-walk (inside WB when writebacks exist), with a pending request outstanding.
        init_mem(2);
        for (int s = 0; s < TS; s++) for (int w = 0; w < TW; w++) dly[s][w] = 6;
        base_done = done_cnt; base_inv = inv_cnt;
        start_walk(k, d);
        pulse();
        for (int i = 0; i < 40 && !(WB_EN ? wb_req_o : inv_we_o); i++) @(negedge clk);
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {busy_o, done_o, tag_rd_en_o, wb_req_o, inv_we_o, line_set_o, line_way_o}, 0);
        q_rd.delete(); q_wb.delete(); q_inv.delete(); q_done.delete();
        for (int i = cyc; i < MAXC; i++) busy_exp[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        in_reset = 1'b0;
        base_inv = inv_cnt;
        wait_cyc(cyc + 12);
        chk("post_reset_no_done", done_cnt - base_done, 0);
        chk("post_reset_no_inv", inv_cnt - base_inv, 0);

        // Random contents, random gaps, occasional coalesced rerun.
        for (int it = 0; it < 5; it++) begin
            init_mem(3);
            wait_cyc(cyc + $urandom_range(1, 6));
            base_done = done_cnt;
            start_walk(k, d);
            if ($urandom_range(0, 1) == 1) begin
                wait_cyc(k + 1 + $urandom_range(0, d - k - 3));
                plan(d, d2);
                pulse();
                wait_cyc(d2 + 3);
                chk("rand_done_pulses", done_cnt - base_done, 2);
            end else begin
                wait_cyc(d + 3);
                chk("rand_done_pulses", done_cnt - base_done, 1);
            end
        end

        chk("rd_left", q_rd.size(), 0);
        chk("wb_left", q_wb.size(), 0);
        chk("inv_left", q_inv.size(), 0);
        chk("done_left", q_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cache_flush_seq.md
# cache_flush_seq

Sequencer that executes a full cache flush after each flush request pulse from the cache security control stage, one instance per cache (I and D). It walks every set and way of the tag array, writes back dirty lines through a request/acknowledge port, and invalidates each line. It holds the cache stalled until the walk completes, so no line from the previous context survives an ASID change, an sfence, or a forced flush.

## Interface
- SETS, default 64: sets per cache; power of two, ≥2
- WAYS, default 4: ways per set; power of two, ≥2
- IDX_W, default $clog2(SETS): set index width
- WAY_W, default $clog2(WAYS): way index width
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- flush_req_i  in  1  flush request pulse (ic_flush_req / dc_flush_req)
- busy_o  out  1  walk in progress; drives the cache lookup stall
- done_o  out  1  one-cycle pulse when a walk completes
- tag_rd_en_o  out  1  tag/state array read strobe
- line_set_o  out  IDX_W  set under operation; shared by read, writeback and invalidate
- line_way_o  out  WAY_W  way under operation
- tag_valid_i  in  1  valid bit; the tag array returns it one cycle after tag_rd_en_o
- tag_dirty_i  in  1  dirty bit; same timing as tag_valid_i
- wb_req_o  out  1  writeback request for line_set_o/line_way_o
- wb_ack_i  in  1  writeback accepted
- inv_we_o  out  1  one-cycle write clearing valid and dirty at line_set_o/line_way_o

## Operation
- FSM states:
  - IDLE: on flush_req_i=1, clear set and way counters to 0, then go to READ.
  - READ: assert tag_rd_en_o for one cycle, then go to CHECK.
  - CHECK: if tag_valid_i && tag_dirty_i, go to WB; otherwise go to INV.
  - WB: hold wb_req_o=1 with stable set/way until wb_ack_i=1 is sampled; then go to INV.
  - INV: assert inv_we_o for one cycle, then advance.
  - DONE: assert done_o for one cycle, then go to IDLE, or to READ if a request is pending.
- Advance from INV:
  - Increment way.
  - If the way was WAYS-1, wrap the way to 0 and increment the set.
  - If set = SETS-1 and way = WAYS-1, go to DONE; otherwise go to READ.
- Counters are exactly IDX_W and WAY_W bits; wrap is natural modulo.
- Every line is invalidated regardless of valid state. No way mask applies: disabled ways are flushed too.
- Requests during a walk: flush_req_i while busy sets a one-deep pending bit; further pulses coalesce into it. DONE clears the pending bit and restarts the walk from set 0 / way 0.
- A flush_req_i in the DONE cycle also counts as pending.
- Outputs:
  - busy_o = (state ≠ IDLE), registered.
  - line_set_o/line_way_o come directly from the counters.
  - All outputs are 0 in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pending 0.
- Asynchronous reset mid-walk abandons the walk immediately. The cache is reset in the same event, so a partial flush is acceptable.
- flush_req_i sampled at edge k → busy_o=1 from cycle k+1; the first tag_rd_en_o is in cycle k+1.
- Per line: 3 cycles (READ, CHECK, INV) when clean or invalid; 3+n cycles when dirty, where n ≥ 1 is the number of WB cycles up to and including the ack.
- Walk with no dirty lines: done_o in cycle k+1+3·SETS·WAYS; busy_o drops in the following cycle.
- WB handshake: wb_req_o never deasserts before the ack. An ack present in the first WB cycle completes in that cycle. wb_ack_i outside WB is ignored.

## Configuration
- CACHE_FLUSH_WB_EN defined: the WB state, wb_req_o handshake and dirty check are active. Use this for the D-cache and any write-back cache.
- CACHE_FLUSH_WB_EN undefined:
  - CHECK always goes to INV.
  - wb_req_o is tied to 0.
  - tag_dirty_i and wb_ack_i are unused.
  - Use this for the I-cache and write-through caches.
  - Cycle timing for clean lines is identical in both builds.

## Structure
- Shared package cache_sec_pkg: FSM state enum (IDLE, READ, CHECK, WB, INV, DONE) and the default SETS/WAYS constants shared with the cache security control and cache tops.
- One natural sub-module: cache_flush_ctr, the set/way counter with clear, advance and last-line flag. Everything else stays in the top.

## Test plan
- SETS=4, WAYS=2, all lines clean; pulse flush_req_i at cycle 0 → 8 inv_we_o pulses in order (0,0),(0,1),(1,0)…(3,1); done_o at cycle 25; busy_o cycles 1–25.
- Line (2,1) valid+dirty, wb_ack_i delayed 4 cycles → wb_req_o held 5 cycles with set=2/way=1 stable, then inv_we_o at (2,1); done_o 5 cycles later than the clean case.
- flush_req_i pulsed twice during a walk → exactly one extra full walk after the first done_o, and exactly two done_o pulses in total.
- rst_n asserted during WB → all outputs 0 asynchronously; after release, IDLE with no spurious inv_we_o or done_o.
- Without CACHE_FLUSH_WB_EN and all lines dirty → wb_req_o never asserts; timing matches the all-clean case.
- Line valid=0 with dirty=1 → no wb_req_o; inv_we_o is still issued for that line.
